mem_arbiter: RTL and testbench

//  - Shares the single main-memory port between the instruction-memory controller (I) and the

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_rr_pick2.sv | 11 +
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state encoding and round-robin rule for mem_arbiter
package mem_arbiter_pkg;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LINE_WIDTH_DEF = 128;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_WAIT = 2'd1,
    ARB_D_WAIT = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;
  // D wins unless I is also asking and D was the side served last
  function automatic logic rr_grant_d(input logic req_i, input logic req_d, input logic last_d);
    return req_d & (~req_i | ~last_d);
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker, grant_d high selects the D requester
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic grant_d
);
  assign grant_d = rr_grant_d(req_i, req_d, last_d);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the I and D cache controllers
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  arb_state_t            r_state, w_next;
  logic                  r_last_d;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [LINE_WIDTH-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;
  logic                  w_grant_d, w_grant, w_wait;
  rr_pick2 u_pick (
    .req_i  (i_req),
    .req_d  (d_req),
    .last_d (r_last_d),
    .grant_d(w_grant_d)
  );
  always_comb begin
    w_next  = r_state;
    w_wait  = (r_state == ARB_I_WAIT) || (r_state == ARB_D_WAIT);
    w_grant = (r_state == ARB_IDLE) && (i_req || d_req);
    mem_req = w_wait;
    busy    = r_state != ARB_IDLE;
    i_ack   = (r_state == ARB_RESP) && !r_last_d;
    d_ack   = (r_state == ARB_RESP) && r_last_d;
    unique case (r_state)
      ARB_IDLE:               w_next = w_grant ? (w_grant_d ? ARB_D_WAIT : ARB_I_WAIT) : ARB_IDLE;
      ARB_I_WAIT, ARB_D_WAIT: w_next = mem_ready ? ARB_RESP : r_state;
      default:                w_next = ARB_IDLE;
    endcase
  end
  // r_last_d doubles as the "who is being served" flag until RESP ends
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_last_d    <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last_d    <= w_grant_d;
        r_mem_addr  <= w_grant_d ? d_addr : i_addr;
        r_mem_write <= w_grant_d && d_write;
        if (w_grant_d) r_mem_wdata <= d_wdata;
      end
      if (mem_ready && r_state == ARB_I_WAIT) r_i_rdata <= mem_rdata;
      if (mem_ready && r_state == ARB_D_WAIT && !r_mem_write) r_d_rdata <= mem_rdata;
    end
  end
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus randomized traffic against a line-memory reference model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, i_ack, d_req, d_write, d_ack;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_write, mem_ready, busy;
  logic          resp, spur;
  int            vectors = 0;
  int            miscompares = 0;
  int            mem_lat = 1;
  logic [LW-1:0] mem_model [logic [AW-1:0]];
  logic [LW-1:0] exp_i, exp_d;
  logic          last_was_d;
  assign mem_ready = resp | spur;
  always #5 clock = ~clock;
  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );
  function automatic logic [LW-1:0] rd(input logic [AW-1:0] a);
    return mem_model.exists(a) ? mem_model[a] : {4{a ^ 32'h5A5A_0000}};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // memory: answers mem_ladt cycles into a request, garbage on mem_rdata otherwise
  initial begin : responder
    int            cnt;
    logic          act, w0;
    logic [AW-1:0] a0;
    logic [LW-1:0] d0;
    cnt = 0; act = 0; w0 = 0; a0 = '0; d0 = '0; resp = 0; mem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (reset || resp) begin
        resp = 0; cnt = 0; act = 0;
      end else if (mem_req) begin
        if (!act) begin
          act = 1; a0 = mem_addr; w0 = mem_write; d0 = mem_wdata;
        end else begin
          vectors++;
          if (mem_addr !== a0 || mem_write !== w0 || mem_wdata !== d0) begin
            miscompares++;
            $display("FAIL mem_stable: addr=%h write=%b, required addr=%h write=%b", mem_addr, mem_write, a0, w0);
          end
        end
        cnt++;
        if (cnt >= mem_lat) begin
          resp = 1;
          if (w0) mem_model[a0] = d0;
          else mem_rdata = rd(a0);
        end
      end
    end
  end
  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    vectors++;
    if ({mem_req, mem_write, i_ack, d_ack, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req/wr/iack/dack/busy=%b, required 00000", {mem_req, mem_write, i_ack, d_ack, busy});
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_mem: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
    end
    vectors++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: i=%h d=%h, required 0", i_rdata, d_rdata);
    end
    reset = 0;
    exp_i = '0; exp_d = '0; last_was_d = 0;
    tick();
  endtask
  task automatic test_i_read();
    mem_model[32'h100] = {16{8'hA5}};
    mem_lat = 5;
    i_addr = 32'h100;
    i_req = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      vectors++;
      if (mem_req !== (c <= 5) || busy !== (c <= 6)) begin
        miscompares++;
        $display("FAIL i_read_req c%0d: mem_req=%b busy=%b, required %b %b", c, mem_req, busy, c <= 5, c <= 6);
      end
      if (c <= 5) begin
        vectors++;
        if (mem_write !== 1'b0 || mem_addr !== 32'h100) begin
          miscompares++;
          $display("FAIL i_read_addr c%0d: write=%b addr=%h, required 0 100", c, mem_write, mem_addr);
        end
      end
      vectors++;
      if (i_ack !== (c == 6) || d_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL i_read_ack c%0d: i_ack=%b d_ack=%b, required %b 0", c, i_ack, d_ack, c == 6);
      end
      if (c == 6) begin
        i_req = 0;
        exp_i = {16{8'hA5}};
        vectors++;
        if (i_rdata !== exp_i) begin
          miscompares++;
          $display("FAIL i_read_data: %h, required %h", i_rdata, exp_i);
        end
      end
    end
  endtask
  task automatic test_d_write();
    int n;
    logic [LW-1:0] wd;
    wd = {4{32'h1234_5678}};
    mem_lat = 2;
    d_addr = 32'h2000; d_write = 0; d_req = 1;
    n = 0;
    do begin tick(); n++; end while (d_ack !== 1'b1 && n < 40);
    d_req = 0;
    exp_d = rd(32'h2000);
    vectors++;
    if (d_ack !== 1'b1 || d_rdata !== exp_d) begin
      miscompares++;
      $display("FAIL d_read_pre: ack=%b data=%h, required 1 %h", d_ack, d_rdata, exp_d);
    end
    tick();
    mem_lat = 3;
    d_write = 1; d_wdata = wd; d_req = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 3) begin
        vectors++;
        if (mem_req !== 1'b1 || mem_write !== 1'b1 || mem_wdata !== wd || mem_addr !== 32'h2000) begin
          miscompares++;
          $display("FAIL d_write_bus c%0d: req=%b wr=%b addr=%h wdata=%h, required 1 1 2000 %h", c, mem_req, mem_write, mem_addr, mem_wdata, wd);
        end
      end
      vectors++;
      if (d_ack !== (c == 4) || i_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL d_write_ack c%0d: d_ack=%b i_ack=%b, required %b 0", c, d_ack, i_ack, c == 4);
      end
      if (c == 4) begin
        d_req = 0;
        vectors++;
        if (d_rdata !== exp_d) begin
          miscompares++;
          $display("FAIL d_write_rdata: %h, required unchanged %h", d_rdata, exp_d);
        end
      end
    end
    d_write = 0; d_req = 1;
    n = 0;
    do begin tick(); n++; end while (d_ack !== 1'b1 && n < 40);
    d_req = 0;
    exp_d = wd;
    vectors++;
    if (d_ack !== 1'b1 || d_rdata !== wd) begin
      miscompares++;
      $display("FAIL d_readback: ack=%b data=%h, required 1 %h", d_ack, d_rdata, wd);
    end
    tick();
  endtask
  task automatic test_tie();
    int n;
    logic want_d;
    reset = 1;
    tick();
    reset = 0;
    exp_i = '0; exp_d = '0; last_was_d = 0;
    i_addr = 32'h300; d_addr = 32'h400; d_write = 0;
    i_req = 1; d_req = 1;
    for (int t = 0; t < 3; t++) begin
      mem_lat = $urandom_range(1, 4);
      want_d = !last_was_d;
      n = 0;
      do begin tick(); n++; end while (!(i_ack || d_ack) && n < 40);
      vectors++;
      if ({i_ack, d_ack} !== (want_d ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL tie_order t%0d: i_ack/d_ack=%b, required %b", t, {i_ack, d_ack}, want_d ? 2'b01 : 2'b10);
      end
      if (want_d) exp_d = rd(32'h400);
      else exp_i = rd(32'h300);
      vectors++;
      if (i_rdata !== exp_i || d_rdata !== exp_d) begin
        miscompares++;
        $display("FAIL tie_data t%0d: i=%h d=%h, required %h %h", t, i_rdata, d_rdata, exp_i, exp_d);
      end
      last_was_d = want_d;
    end
    i_req = 0; d_req = 0;
    tick();
    tick();
  endtask
  task automatic test_back_to_back();
    int n, d_before_i;
    logic seq [3] = '{1'b1, 1'b0, 1'b1};
    logic i_done;
    mem_lat = 2;
    d_addr = 32'h500; d_write = 0; d_req = 1;
    tick();
    i_addr = 32'h540; i_req = 1;
    d_before_i = 0; i_done = 0;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      do begin tick(); n++; end while (!(i_ack || d_ack) && n < 40);
      vectors++;
      if ({i_ack, d_ack} !== (seq[t] ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL b2b_order t%0d: i_ack/d_ack=%b, required %b", t, {i_ack, d_ack}, seq[t] ? 2'b01 : 2'b10);
      end
      if (d_ack && !i_done) d_before_i++;
      if (i_ack) begin
        i_req = 0; i_done = 1; exp_i = rd(32'h540);
      end
      if (d_ack) exp_d = rd(32'h500);
      last_was_d = d_ack;
    end
    d_req = 0;
    vectors++;
    if (d_before_i > 1 || !i_done) begin
      miscompares++;
      $display("FAIL b2b_starve: D txns before I=%0d served=%b, required <=1 1", d_before_i, i_done);
    end
    tick();
    tick();
  endtask
  task automatic test_spurious();
    for (int p = 0; p < 2; p++) begin
      spur = 1;
      tick();
      spur = 0;
      vectors++;
      if ({i_ack, d_ack, busy, mem_req} !== 4'b0) begin
        miscompares++;
        $display("FAIL spur_ctrl p%0d: iack/dack/busy/req=%b, required 0000", p, {i_ack, d_ack, busy, mem_req});
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0 || i_rdata !== exp_i || d_rdata !== exp_d) begin
        miscompares++;
        $display("FAIL spur_after p%0d: busy=%b acks=%b%b i=%h d=%h, required idle, data %h %h", p, busy, i_ack, d_ack, i_rdata, d_rdata, exp_i, exp_d);
      end
    end
  endtask
  task automatic test_reset_mid();
    mem_lat = 20;
    i_addr = 32'h600; i_req = 1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b1) begin
        miscompares++;
        $display("FAIL rmid_wait c%0d: mem_req=%b, required 1", c, mem_req);
      end
    end
    reset = 1;
    tick();
    vectors++;
    if ({mem_req, busy, i_ack, d_ack} !== 4'b0 || i_rdata !== '0) begin
      miscompares++;
      $display("FAIL rmid_abort: req/busy/iack/dack=%b i_rdata=%h, required 0000 0", {mem_req, busy, i_ack, d_ack}, i_rdata);
    end
    reset = 0;
    exp_i = '0; exp_d = '0; last_was_d = 0;
    mem_lat = 3;
    for (int c = 4; c <= 8; c++) begin
      tick();
      vectors++;
      if (i_ack !== (c == 7) || busy !== (c <= 7)) begin
        miscompares++;
        $display("FAIL rmid_fresh c%0d: i_ack=%b busy=%b, required %b %b", c, i_ack, busy, c == 7, c <= 7);
      end
      if (c == 7) begin
        i_req = 0;
        exp_i = rd(32'h600);
        vectors++;
        if (i_rdata !== exp_i) begin
          miscompares++;
          $display("FAIL rmid_data: %h, required %h", i_rdata, exp_i);
        end
      end
    end
  endtask
  task automatic test_random();
    logic pend_i, pend_d, just_i, just_d;
    int wait_i, wait_d;
    pend_i = 0; pend_d = 0; wait_i = 0; wait_d = 0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      tick();
      mem_lat = $urandom_range(1, 4);
      just_i = 0; just_d = 0;
      vectors++;
      if (i_ack && d_ack) begin
        miscompares++;
        $display("FAIL rnd_both_ack cyc%0d: i_ack=1 d_ack=1, required at most one", cyc);
      end
      if (i_ack) begin
        exp_i = rd(i_addr);
        vectors++;
        if (!pend_i || i_rdata !== exp_i || wait_i > 1) begin
          miscompares++;
          $display("FAIL rnd_i cyc%0d: pending=%b data=%h waits=%0d, required 1 %h <=1", cyc, pend_i, i_rdata, exp_i, wait_i);
        end
        i_req = 0; pend_i = 0; just_i = 1;
        if (pend_d) wait_d++;
      end
      if (d_ack) begin
        if (!d_write) exp_d = rd(d_addr);
        vectors++;
        if (!pend_d || d_rdata !== exp_d || wait_d > 1) begin
          miscompares++;
          $display("FAIL rnd_d cyc%0d: pending=%b data=%h waits=%0d, required 1 %h <=1", cyc, pend_d, d_rdata, exp_d, wait_d);
        end
        d_req = 0; pend_d = 0; just_d = 1;
        if (pend_i) wait_i++;
      end
      if (cyc < 400 && !pend_i && !just_i && $urandom_range(0, 2) == 0) begin
        i_addr = AW'($urandom_range(0, 7)) << 4;
        i_req = 1; pend_i = 1; wait_i = 0;
      end
      if (cyc < 400 && !pend_d && !just_d && $urandom_range(0, 2) == 0) begin
        d_addr = AW'($urandom_range(0, 7)) << 4;
        d_write = $urandom_range(0, 1) == 1;
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
        d_req = 1; pend_d = 1; wait_d = 0;
      end
    end
    vectors++;
    if (pend_i || pend_d) begin
      miscompares++;
      $display("FAIL rnd_drain: pending i=%b d=%b, required both served", pend_i, pend_d);
    end
  endtask
  initial begin
    reset = 1; spur = 0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_i_read();
    test_d_write();
    test_tie();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule
